// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate decode/extend into a DEPTH-entry output FIFO; `IMM_ZEXT_EN enables imm_sel[3] zero-extension
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [3:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             sel_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef IMM_ZEXT_EN
    localparam bit ZEXT_EN = 1'b1;
`else
    localparam bit ZEXT_EN = 1'b0;
`endif

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;
    logic             top_bit;
    logic             unused_inst;

    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic             mem_err [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Opcode bits never contribute to any immediate.
    assign unused_inst = &{1'b0, inst[6:0]};

    // Sign source for J/I/B/S; forced low when zero-extension is requested.
    assign top_bit = inst[31] & ~(imm_sel[3] & ZEXT_EN);

    always_comb begin
        dec_imm = '0;
        dec_err = 1'b0;
        case (imm_sel[2:0])
            3'b000: dec_imm = XLEN'($signed({inst[31:12], 12'b0}));
            3'b001: dec_imm = XLEN'($signed({top_bit, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            3'b010: dec_imm = XLEN'($signed({top_bit, inst[31:20]}));
            3'b011: dec_imm = XLEN'($signed({top_bit, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            3'b100: dec_imm = XLEN'($signed({top_bit, inst[31:25], inst[11:7]}));
            3'b101: dec_imm = XLEN'({((XLEN == 64) ? inst[25] : 1'b0), inst[24:20]});
            default: dec_err = 1'b1;
        endcase
    end

    assign in_ready = ~RESET & ((count < CNT_W'(DEPTH)) | out_ready);
    assign out_valid = (count != '0);
    assign push = in_valid & in_ready & ~FLUSH;
    assign pop = out_valid & out_ready & ~FLUSH;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_imm[wr_ptr] <= dec_imm;
            mem_tag[wr_ptr] <= in_tag;
            mem_err[wr_ptr] <= dec_err;
        end
    end

    assign imm_ext = out_valid ? mem_imm[rd_ptr] : '0;
    assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;
    assign sel_err = out_valid ? mem_err[rd_ptr] : 1'b0;

endmodule
